// File: rtl/cpu_mem_map_pkg.sv
// Shared memory-map definitions for the data-memory responder.
// Holds the MMIO window selector, the register offsets inside the window,
// the STATUS bit positions and a helper that turns an offset into a
// register select.
package cpu_mem_map_pkg;

    localparam logic [15:0] MMIO_HI    = 16'hFFFF;

    localparam logic [15:0] CYCLE_OFS  = 16'h0000;
    localparam logic [15:0] LOADS_OFS  = 16'h0004;
    localparam logic [15:0] STORES_OFS = 16'h0008;
    localparam logic [15:0] STATUS_OFS = 16'h000C;
    localparam logic [15:0] RESULT_OFS = 16'h0010;

    localparam int HALT_BIT     = 0;
    localparam int MISALIGN_BIT = 1;

    typedef enum logic [2:0] {
        SEL_CYCLE,
        SEL_LOADS,
        SEL_STORES,
        SEL_STATUS,
        SEL_RESULT,
        SEL_NONE
    } mmio_sel_e;

    // The offset is expected with its byte-lane bits already cleared, so a
    // misaligned access resolves to the word that contains it.
    function automatic mmio_sel_e decode_offset(input logic [15:0] ofs);
        mmio_sel_e sel;
        case (ofs)
            CYCLE_OFS:  sel = SEL_CYCLE;
            LOADS_OFS:  sel = SEL_LOADS;
            STORES_OFS: sel = SEL_STORES;
            STATUS_OFS: sel = SEL_STATUS;
            RESULT_OFS: sel = SEL_RESULT;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cpu_mmio_regs.sv
// MMIO register bank: free-running cycle counter, RAM load/store counters,
// STATUS (halt / sticky misalign) and the RESULT scratch register.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   rd_i               MMIO read strobe (gates rdata_o)
//   wr_i               aligned MMIO store strobe
//   offset_i[15:2]     word offset inside the MMIO window
//   wdata_i            store data
//   ramLoad_i          a counted RAM load happens this cycle
//   ramStore_i         a counted RAM store happens this cycle
//   misalignEvt_i      an access with Address[1:0] != 0 happens this cycle
//   rdata_o            register read data (0 when rd_i is low)
//   halt_o, misalign_o STATUS flags
module cpu_mmio_regs
    import cpu_mem_map_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [15:2] offset_i,
    input  logic [31:0] wdata_i,
    input  logic        ramLoad_i,
    input  logic        ramStore_i,
    input  logic        misalignEvt_i,
    output logic [31:0] rdata_o,
    output logic        halt_o,
    output logic        misalign_o
);

    logic [31:0] cycle_q,  cycle_d;
    logic [31:0] loads_q,  loads_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] result_q, result_d;
    logic        halt_q,   halt_d;
    logic        misalign_q, misalign_d;
    mmio_sel_e   sel;

    assign sel = decode_offset({offset_i, 2'b00});

    // Once halted every counter and every write freezes; only a new
    // misaligned access may still raise the sticky flag, and it beats a
    // same-cycle W1C because it is applied last.
    always_comb begin
        cycle_d    = cycle_q;
        loads_d    = loads_q;
        stores_d   = stores_q;
        result_d   = result_q;
        halt_d     = halt_q;
        misalign_d = misalign_q;
        if (!halt_q) begin
            cycle_d = cycle_q + 32'd1;
            if (ramLoad_i) begin
                loads_d = loads_q + 32'd1;
            end
            if (ramStore_i) begin
                stores_d = stores_q + 32'd1;
            end
            if (wr_i && sel == SEL_RESULT) begin
                result_d = wdata_i;
            end
            if (wr_i && sel == SEL_STATUS) begin
                if (wdata_i[HALT_BIT]) begin
                    halt_d = 1'b1;
                end
                if (wdata_i[MISALIGN_BIT]) begin
                    misalign_d = 1'b0;
                end
            end
        end
        if (misalignEvt_i) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q    <= '0;
            loads_q    <= '0;
            stores_q   <= '0;
            result_q   <= '0;
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            loads_q    <= loads_d;
            stores_q   <= stores_d;
            result_q   <= result_d;
            halt_q     <= halt_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rd_i) begin
            case (sel)
                SEL_CYCLE:  rdata_o = cycle_q;
                SEL_LOADS:  rdata_o = loads_q;
                SEL_STORES: rdata_o = stores_q;
                SEL_STATUS: begin
                    rdata_o[HALT_BIT]     = halt_q;
                    rdata_o[MISALIGN_BIT] = misalign_q;
                end
                SEL_RESULT: rdata_o = result_q;
                default:    rdata_o = '0;
            endcase
        end
    end

    assign halt_o     = halt_q;
    assign misalign_o = misalign_q;

endmodule

// File: rtl/cpu_data_mem.sv
// Data-memory responder for the single-cycle MIPS core: word-addressed RAM
// with combinational reads and clocked stores, plus an MMIO window of
// counters/status/result registers.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   Address       byte address from the core
//   MemRead       load request (combinational data this cycle)
//   MemWrite      store request (committed at the next posedge)
//   Write_data    store data
//   Read_data     load data, 0 when MemRead is low
//   halt          program-requested stop, cleared only by rst
//   misalign      sticky flag for any access with Address[1:0] != 0
module cpu_data_mem #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] MMIO_HI    = cpu_mem_map_pkg::MMIO_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        halt,
    output logic        misalign
);

    import cpu_mem_map_pkg::*;

    logic [31:0]           ram_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ramIdx;
    logic                  isMmio;
    logic                  isAligned;
    logic                  misalignEvt;
    logic                  storeOk;
    logic                  ramStore;
    logic                  ramLoad;
    logic                  mmioWr;
    logic                  mmioRd;
    logic [31:0]           mmioRdata;

    // Upper RAM address bits are ignored so the RAM aliases modulo depth.
    // A load that coincides with a store is treated as the store only.
    assign isMmio      = (Address[31:16] == MMIO_HI);
    assign ramIdx      = Address[ADDR_WIDTH+1:2];
    assign isAligned   = (Address[1:0] == 2'b00);
    assign misalignEvt = (MemRead || MemWrite) && !isAligned;
    assign storeOk     = MemWrite && isAligned;
    assign ramStore    = storeOk && !isMmio;
    assign mmioWr      = storeOk && isMmio;
    assign ramLoad     = MemRead && !MemWrite && isAligned && !isMmio;
    assign mmioRd      = MemRead && isMmio;

    cpu_mmio_regs uRegs (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_i          (mmioRd),
        .wr_i          (mmioWr),
        .offset_i      (Address[15:2]),
        .wdata_i       (Write_data),
        .ramLoad_i     (ramLoad),
        .ramStore_i    (ramStore),
        .misalignEvt_i (misalignEvt),
        .rdata_o       (mmioRdata),
        .halt_o        (halt),
        .misalign_o    (misalign)
    );

    // RAM contents survive reset; a store issued alongside rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && ramStore && !halt) begin
            ram_q[ramIdx] <= Write_data;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            Read_data = isMmio ? mmioRdata : ram_q[ramIdx];
        end
    end

endmodule

// File: tb/tb_cpu_data_mem.sv
// Directed self-checking bench for cpu_data_mem. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge that commits state.
module tb_cpu_data_mem;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        halt;
    logic        misalign;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] tbCycles = 0;
    logic [31:0] haltCycles;

    cpu_data_mem #(.ADDR_WIDTH(8), .MMIO_HI(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .Address    (Address),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .halt       (halt),
        .misalign   (misalign)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of non-reset rising edges; matches CYCLE until halt.
    always @(posedge clk) begin
        if (rst) tbCycles <= 32'd0;
        else     tbCycles <= tbCycles + 32'd1;
    end

    // One cycle of stimulus: wait for the falling edge, then drive the bus.
    task automatic applyStimulus(input logic [31:0] addr, input logic rd,
                                 input logic wr, input logic [31:0] data);
        @(negedge clk);
        Address    = addr;
        MemRead    = rd;
        MemWrite   = wr;
        Write_data = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        Address    = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Write_data = '0;
        repeat (2) @(posedge clk);

        // First cycle after reset: flags clear, CYCLE reads 0, then 5 later.
        @(negedge clk);
        rst     = 1'b0;
        Address = 32'hFFFF_0000;
        MemRead = 1'b1;
        #1;
        checkOutput("reset_halt", {31'b0, halt}, 32'd0);
        checkOutput("reset_misalign", {31'b0, misalign}, 32'd0);
        checkOutput("cycle_first", Read_data, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("cycle_after5", Read_data, 32'd5);
        applyStimulus(32'hFFFF_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("loads_reset", Read_data, 32'd0);
        applyStimulus(32'hFFFF_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("stores_reset", Read_data, 32'd0);
        applyStimulus(32'hFFFF_0010, 1'b1, 1'b0, 32'd0);
        checkOutput("result_reset", Read_data, 32'd0);

        // Basic store/load, aliasing and counters.
        applyStimulus(32'h0000_0000, 1'b0, 1'b1, 32'h0000_1111);
        applyStimulus(32'h0000_0040, 1'b0, 1'b1, 32'h1234_5678);
        applyStimulus(32'h0000_0040, 1'b1, 1'b0, 32'd0);
        checkOutput("lw_0x40", Read_data, 32'h1234_5678);
        applyStimulus(32'h0000_0440, 1'b1, 1'b0, 32'd0);
        checkOutput("lw_alias_0x440", Read_data, 32'h1234_5678);
        applyStimulus(32'hFFFF_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("stores_two", Read_data, 32'd2);
        applyStimulus(32'hFFFF_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("loads_two", Read_data, 32'd2);
        applyStimulus(32'h0000_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("read_off", Read_data, 32'h0000_1111);
        applyStimulus(32'h0000_0000, 1'b0, 1'b0, 32'd0);
        checkOutput("read_gated", Read_data, 32'd0);

        // Simultaneous read+write: old data now, new data next cycle.
        applyStimulus(32'h0000_0008, 1'b0, 1'b1, 32'h0000_000A);
        applyStimulus(32'h0000_0008, 1'b1, 1'b1, 32'h0000_000B);
        checkOutput("rdwr_old", Read_data, 32'h0000_000A);
        applyStimulus(32'h0000_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("rdwr_new", Read_data, 32'h0000_000B);
        applyStimulus(32'hFFFF_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("loads_rdwr_excluded", Read_data, 32'd4);

        // Misaligned store is suppressed and flags misalign; W1C clears it.
        applyStimulus(32'h0000_0042, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_0040, 1'b1, 1'b0, 32'd0);
        checkOutput("misalign_set", {31'b0, misalign}, 32'd1);
        checkOutput("misaligned_sw_dropped", Read_data, 32'h1234_5678);
        applyStimulus(32'hFFFF_000C, 1'b1, 1'b0, 32'd0);
        checkOutput("status_misalign", Read_data, 32'h0000_0002);
        applyStimulus(32'hFFFF_000C, 1'b0, 1'b1, 32'h0000_0002);
        applyStimulus(32'hFFFF_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("misalign_w1c", {31'b0, misalign}, 32'd0);
        checkOutput("stores_after_misalign", Read_data, 32'd4);

        // Misaligned read returns the aligned word; misaligned W1C loses.
        applyStimulus(32'h0000_0043, 1'b1, 1'b0, 32'd0);
        checkOutput("misaligned_lw", Read_data, 32'h1234_5678);
        applyStimulus(32'hFFFF_000E, 1'b0, 1'b1, 32'h0000_0002);
        checkOutput("misalign_read_set", {31'b0, misalign}, 32'd1);
        applyStimulus(32'hFFFF_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("misalign_set_wins", {31'b0, misalign}, 32'd1);
        checkOutput("loads_misaligned_excluded", Read_data, 32'd5);
        applyStimulus(32'hFFFF_000C, 1'b0, 1'b1, 32'h0000_0002);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("misalign_cleared", {31'b0, misalign}, 32'd0);
        checkOutput("cycle_tracks", Read_data, tbCycles);

        // Counter wrap: preload STORES to all-ones, then one store wraps it.
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        force dut.uRegs.stores_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.uRegs.stores_q;
        Address = 32'hFFFF_0008;
        MemRead = 1'b1;
        #1;
        checkOutput("stores_preload", Read_data, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_0010, 1'b0, 1'b1, 32'h0000_0005);
        applyStimulus(32'hFFFF_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("stores_wrap", Read_data, 32'd0);

        // RESULT then halt; everything freezes but reads keep working.
        applyStimulus(32'hFFFF_0010, 1'b0, 1'b1, 32'h0000_DEAD);
        applyStimulus(32'hFFFF_000C, 1'b0, 1'b1, 32'h0000_0001);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("halt_set", {31'b0, halt}, 32'd1);
        checkOutput("cycle_at_halt", Read_data, tbCycles);
        haltCycles = tbCycles;
        applyStimulus(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0077);
        applyStimulus(32'h0000_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("halted_sw_ignored", Read_data, 32'h0000_1111);
        applyStimulus(32'hFFFF_0010, 1'b0, 1'b1, 32'h0000_BEEF);
        applyStimulus(32'hFFFF_0010, 1'b1, 1'b0, 32'd0);
        checkOutput("result_kept", Read_data, 32'h0000_DEAD);
        applyStimulus(32'hFFFF_0008, 1'b1, 1'b0, 32'd0);
        checkOutput("stores_frozen", Read_data, 32'd0);
        applyStimulus(32'hFFFF_0004, 1'b1, 1'b0, 32'd0);
        checkOutput("loads_frozen", Read_data, 32'd5);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("cycle_frozen", Read_data, haltCycles);

        // Reset mid-program with a concurrent store that must be dropped.
        @(negedge clk);
        rst        = 1'b1;
        Address    = 32'h0000_0000;
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        Write_data = 32'h0000_0099;
        @(negedge clk);
        rst      = 1'b0;
        MemWrite = 1'b0;
        Address  = 32'hFFFF_0010;
        MemRead  = 1'b1;
        #1;
        checkOutput("rst_halt_clear", {31'b0, halt}, 32'd0);
        checkOutput("rst_misalign_clear", {31'b0, misalign}, 32'd0);
        checkOutput("rst_result_clear", Read_data, 32'd0);
        applyStimulus(32'h0000_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("rst_ram_kept", Read_data, 32'h0000_1111);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b0, 32'd0);
        checkOutput("rst_cycle_restart", Read_data, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
